// File: rtl/arbitro_vc_pkg.sv
// Shared encodings and field positions for the VC arbiter, FIFO bank and state machine.
package arbitro_vc_pkg;
   localparam int N_FIFOS  = 4;
   localparam int DATA_W   = 6;
   localparam int DEST_W   = 2;
   localparam int DEST_MSB = DATA_W - 1;
   localparam int DEST_LSB = DATA_W - 2;

   typedef enum logic [1:0] {
      ARB_DISABLED = 2'd0,
      ARB_RUN      = 2'd1,
      ARB_DRAIN    = 2'd2,
      ARB_ILLEGAL  = 2'd3
   } arb_state_t;

   // Index of the set bit in a one-hot 4-bit vector (0 when empty).
   function automatic logic [1:0] onehot_to_idx(input logic [N_FIFOS-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < N_FIFOS; i++)
         if (oh[i]) idx = 2'(i);
      return idx;
   endfunction
endpackage

// File: rtl/arbitro_vc_rr_selector.sv
// Round-robin pick: first set bit of the eligible mask at or after the pointer.
module rr_selector
   import arbitro_vc_pkg::*;
(
   input  logic [N_FIFOS-1:0] eligible,
   input  logic [1:0]         ptr,
   output logic [N_FIFOS-1:0] grant,
   output logic               valid
);
   // Scan ptr, ptr+1, ... with 2-bit wraparound; first hit wins.
   always_comb begin
      logic [1:0] idx;
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      for (int i = 0; i < N_FIFOS; i++) begin
         idx = ptr + 2'(i);
         if (!valid && eligible[idx]) begin
            grant[idx] = 1'b1;
            valid      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/arbitro_vc.sv
// Round-robin scheduler moving words from 4 input VC FIFOs to 4 destination FIFOs.
module arbitro_vc
   import arbitro_vc_pkg::*;
(
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       active_in,
   input  logic [N_FIFOS-1:0]         fifo_empty,
   input  logic [N_FIFOS*DATA_W-1:0]  fifo_data,
   input  logic [N_FIFOS-1:0]         out_almost_full,
   output logic [N_FIFOS-1:0]         fifo_pop,
   output logic [N_FIFOS-1:0]         out_push,
   output logic [DATA_W-1:0]          out_data,
   output logic [1:0]                 grant_idx,
   output logic [1:0]                 arb_state,
   output logic                       busy
);
   arb_state_t                        state_q, state_d;
   logic [1:0]                        ptr_q;
   logic [N_FIFOS-1:0][DATA_W-1:0]    head;
   logic [N_FIFOS-1:0][DEST_W-1:0]    dest;
   logic [N_FIFOS-1:0]                eligible, grant;
   logic                              grant_vld, xfer;
   logic [1:0]                        gk;

   // Unpack heads and destination fields; an input is eligible when it has
   // data and its destination still has room.
   always_comb begin
      for (int k = 0; k < N_FIFOS; k++) begin
         head[k]     = fifo_data[k*DATA_W +: DATA_W];
         dest[k]     = head[k][DEST_MSB:DEST_LSB];
         eligible[k] = !fifo_empty[k] && !out_almost_full[dest[k]];
      end
   end

   rr_selector u_sel (
      .eligible (eligible),
      .ptr      (ptr_q),
      .grant    (grant),
      .valid    (grant_vld)
   );

   // A transfer happens only in RUN with active_in high and reset released.
   always_comb begin
      xfer     = reset && (state_q == ARB_RUN) && active_in && grant_vld;
      fifo_pop = xfer ? grant : '0;
      gk       = onehot_to_idx(grant);
   end

   // Next-state logic; DRAIN always returns through DISABLED.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_DISABLED: if (active_in)  state_d = ARB_RUN;
         ARB_RUN:      if (!active_in) state_d = ARB_DRAIN;
         ARB_DRAIN:                    state_d = ARB_DISABLED;
         default:                      state_d = ARB_DISABLED;
      endcase
   end

   // State, pointer and registered push path.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ARB_DISABLED;
         ptr_q     <= '0;
         out_push  <= '0;
         out_data  <= '0;
         grant_idx <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ARB_RUN) begin
            if (xfer) begin
               out_data  <= head[gk];
               out_push  <= N_FIFOS'(1) << dest[gk];
               grant_idx <= gk;
               ptr_q     <= gk + 2'd1;
            end else if (active_in) begin
               out_push  <= '0;
            end
            // On exit (active_in low) the pending push carries into DRAIN.
         end else begin
            out_push <= '0;
         end
      end
   end

   assign arb_state = state_q;
   assign busy      = (state_q != ARB_DISABLED);
endmodule

// File: tb/tb_arbitro_vc.sv
// Directed bench for arbitro_vc: reset, single source, rotation, almost-full skip,
// disable/drain and reset mid-stream.
module tb_arbitro_vc;
   logic        clk = 1'b0;
   logic        reset, active_in;
   logic [3:0]  fifo_empty, out_almost_full;
   logic [5:0]  d [4];
   logic [23:0] fifo_data;
   logic [3:0]  fifo_pop, out_push;
   logic [5:0]  out_data;
   logic [1:0]  grant_idx, arb_state;
   logic        busy;
   int          checks = 0;
   int          failures = 0;

   assign fifo_data = {d[3], d[2], d[1], d[0]};

   arbitro_vc dut (
      .clk             (clk),
      .reset           (reset),
      .active_in       (active_in),
      .fifo_empty      (fifo_empty),
      .fifo_data       (fifo_data),
      .out_almost_full (out_almost_full),
      .fifo_pop        (fifo_pop),
      .out_push        (out_push),
      .out_data        (out_data),
      .grant_idx       (grant_idx),
      .arb_state       (arb_state),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   initial begin
      reset = 1'b0; active_in = 1'b1; fifo_empty = 4'b0000; out_almost_full = 4'b0000;
      d[0] = 6'b00_0001; d[1] = 6'b01_0010; d[2] = 6'b10_0011; d[3] = 6'b11_0100;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_pop", 32'(fifo_pop), 32'h0);
      chk("rst_push", 32'(out_push), 32'h0);
      chk("rst_data", 32'(out_data), 32'h0);
      chk("rst_state", 32'(arb_state), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_gidx", 32'(grant_idx), 32'h0);

      // Single source: only FIFO2, head 01_0101
      reset = 1'b1; fifo_empty = 4'b1011; d[2] = 6'b01_0101;
      #1 chk("dis_pop", 32'(fifo_pop), 32'h0);
      @(negedge clk); #1;
      chk("run_state", 32'(arb_state), 32'h1);
      chk("single_pop", 32'(fifo_pop), 32'b0100);
      @(negedge clk);
      fifo_empty = 4'b0111; d[2] = 6'b10_0011;
      #1;
      chk("single_push", 32'(out_push), 32'b0010);
      chk("single_data", 32'(out_data), 32'b010101);
      chk("single_gidx", 32'(grant_idx), 32'd2);
      chk("ptr3_pop", 32'(fifo_pop), 32'b1000);

      // Rotation from pointer 0 with all inputs ready
      @(negedge clk); fifo_empty = 4'b0000; #1;
      chk("rot0", 32'(fifo_pop), 32'b0001);
      @(negedge clk); #1;
      chk("rot1", 32'(fifo_pop), 32'b0010);
      chk("rot_push0", 32'(out_push), 32'b0001);
      chk("rot_data0", 32'(out_data), 32'b000001);
      @(negedge clk); #1;
      chk("rot2", 32'(fifo_pop), 32'b0100);
      chk("rot_push1", 32'(out_push), 32'b0010);
      @(negedge clk); #1;
      chk("rot3", 32'(fifo_pop), 32'b1000);
      chk("rot_push2", 32'(out_push), 32'b0100);
      @(negedge clk); #1;
      chk("rot4", 32'(fifo_pop), 32'b0001);
      chk("rot_push3", 32'(out_push), 32'b1000);

      // Bring pointer back to 0 by granting FIFO3 alone
      @(negedge clk); fifo_empty = 4'b0111; #1;
      chk("solo3_pop", 32'(fifo_pop), 32'b1000);

      // Almost-full skip: FIFO0 -> dest3 blocked, FIFO1 -> dest0
      @(negedge clk);
      d[0] = 6'b11_0000; d[1] = 6'b00_1111; fifo_empty = 4'b1100; out_almost_full = 4'b1000;
      #1 chk("af_skip_pop", 32'(fifo_pop), 32'b0010);
      @(negedge clk); fifo_empty = 4'b1110; out_almost_full = 4'b0000; #1;
      chk("af_wrap_pop", 32'(fifo_pop), 32'b0001);
      @(negedge clk);
      fifo_empty = 4'b0111; d[3] = 6'b10_1010;
      #1;
      chk("af_push", 32'(out_push), 32'b1000);
      chk("af_data", 32'(out_data), 32'b110000);
      chk("af_gidx", 32'(grant_idx), 32'd0);
      chk("dis3_pop", 32'(fifo_pop), 32'b1000);

      // Disable right after FIFO3 grant
      @(negedge clk); active_in = 1'b0; #1;
      chk("exit_pop", 32'(fifo_pop), 32'h0);
      chk("exit_state", 32'(arb_state), 32'h1);
      chk("exit_push", 32'(out_push), 32'b0100);
      @(negedge clk); active_in = 1'b1; #1;
      chk("drain_state", 32'(arb_state), 32'h2);
      chk("drain_busy", 32'(busy), 32'h1);
      chk("drain_push", 32'(out_push), 32'b0100);
      chk("drain_data", 32'(out_data), 32'b101010);
      chk("drain_pop", 32'(fifo_pop), 32'h0);
      @(negedge clk); fifo_empty = 4'b0000; #1;
      chk("post_state", 32'(arb_state), 32'h0);
      chk("post_push", 32'(out_push), 32'h0);
      chk("post_busy", 32'(busy), 32'h0);
      chk("post_gidx", 32'(grant_idx), 32'd3);
      chk("post_pop", 32'(fifo_pop), 32'h0);

      // Reset mid-stream
      @(negedge clk); #1;
      chk("rerun_pop", 32'(fifo_pop), 32'b0001);
      @(negedge clk); reset = 1'b0; #1;
      chk("midrst_pop", 32'(fifo_pop), 32'h0);
      chk("midrst_pend", 32'(out_push), 32'b1000);
      @(negedge clk); reset = 1'b1; #1;
      chk("midrst_push", 32'(out_push), 32'h0);
      chk("midrst_state", 32'(arb_state), 32'h0);
      chk("midrst_gidx", 32'(grant_idx), 32'h0);
      @(negedge clk); #1;
      chk("midrst_ptr", 32'(fifo_pop), 32'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
